// File: rtl/t2mi_packet_framer_if.sv
// t2mi_packet_framer_if: request, payload and byte-stream signals of the T2MI framer
interface t2mi_packet_framer_if;
  logic pkt_req;
  logic [7:0] pkt_type;
  logic [15:0] pkt_length;
  logic pkt_ack;
  logic pkt_reject;
  logic pl_valid;
  logic [7:0] pl_data;
  logic pl_ready;
  logic t2mi_valid;
  logic [7:0] t2mi_data;
  logic t2mi_sync;
  logic busy;
  logic underrun;
  logic [15:0] pkt_count;
  modport master (
    output pkt_req, pkt_type, pkt_length, pl_valid, pl_data,
    input pkt_ack, pkt_reject, pl_ready, t2mi_valid, t2mi_data, t2mi_sync, busy, underrun, pkt_count
  );
  modport slave (
    input pkt_req, pkt_type, pkt_length, pl_valid, pl_data,
    output pkt_ack, pkt_reject, pl_ready, t2mi_valid, t2mi_data, t2mi_sync, busy, underrun, pkt_count
  );
endinterface

// File: rtl/t2mi_packet_framer.sv
// t2mi_packet_framer: paces sync, type, 16-bit length and payload bytes of a T2MI packet
module t2mi_packet_framer #(
  parameter int BYTE_DIV = 1,
  parameter int GAP_CYCLES = 8,
  parameter int MIN_LEN = 4,
  parameter int MAX_LEN = 4096
) (
  input logic clk,
  input logic rst,
  t2mi_packet_framer_if.slave bus
);
  localparam int DW = BYTE_DIV > 1 ? $clog2(BYTE_DIV) : 1;
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [2:0] IDLE = 3'd0, SYNC = 3'd1, TYPE = 3'd2, LEN_HI = 3'd3, LEN_LO = 3'd4, PAYLOAD = 3'd5, GAP = 3'd6;
  logic [2:0] state;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [15:0] rem, len_q;
  logic [7:0] type_q, hdr_byte;
  logic slot, hdr, take, legal, accept;
  assign slot = div_cnt == DW'(BYTE_DIV - 1);
  assign hdr = state inside {SYNC, TYPE, LEN_HI, LEN_LO};
  assign take = bus.pl_ready && bus.pl_valid;
  assign legal = bus.pkt_length >= 16'(MIN_LEN) && bus.pkt_length <= 16'(MAX_LEN);
  assign accept = state == IDLE && bus.pkt_req && legal;
  assign hdr_byte = state == SYNC ? 8'h47 : state == TYPE ? type_q : state == LEN_HI ? len_q[15:8] : len_q[7:0];
  assign bus.pl_ready = state == PAYLOAD && slot;
  assign bus.busy = state != IDLE;
  // Header states advance (in encoding order into PAYLOAD) on each slot; a stalled payload slot keeps div_cnt saturated so it retries every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div_cnt <= '0;
      gap_cnt <= '0;
      rem <= '0;
      len_q <= '0;
      type_q <= '0;
      bus.pkt_ack <= 1'b0;
      bus.pkt_reject <= 1'b0;
      bus.t2mi_valid <= 1'b0;
      bus.t2mi_data <= 8'h00;
      bus.t2mi_sync <= 1'b0;
      bus.underrun <= 1'b0;
      bus.pkt_count <= '0;
    end else begin
      bus.pkt_ack <= accept;
      bus.pkt_reject <= state == IDLE && bus.pkt_req && !legal;
      bus.t2mi_valid <= (hdr && slot) || take;
      bus.t2mi_data <= hdr && slot ? hdr_byte : take ? bus.pl_data : 8'h00;
      bus.t2mi_sync <= state == SYNC && slot;
      bus.underrun <= bus.pl_ready && !bus.pl_valid;
      div_cnt <= (hdr && slot) || take || state == IDLE ? '0 : slot ? div_cnt : div_cnt + 1'b1;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        state <= SYNC;
        type_q <= bus.pkt_type;
        len_q <= bus.pkt_length;
        rem <= bus.pkt_length;
      end
      if (hdr && slot) state <= state + 3'd1;
      if (take) begin
        rem <= rem - 16'd1;
        if (rem == 16'd1) begin
          bus.pkt_count <= bus.pkt_count + 16'd1;
          state <= GAP_CYCLES == 0 ? IDLE : GAP;
        end
      end
      if (state == GAP && gap_cnt == GW'(GAP_CYCLES)) state <= IDLE;
    end
  end
endmodule

// File: doc/t2mi_packet_framer.md
# t2mi_packet_framer

Transmit-side counterpart of the T2MI packet parser. It accepts a packet request (type, length) plus a byte-stream payload and serialises a T2MI packet onto the byte interface the parser consumes:
- sync byte 0x47 with `t2mi_sync`,
- type byte,
- 16-bit length (MSB first),
- payload bytes.

It sits in the stimulus and loopback path ahead of `t2mi_packet_parser`. It paces bytes at a programmable slot rate and enforces the same length limits the parser checks.

## Interface
Parameters:
- BYTE_DIV, 1: clock cycles per byte slot (≥1).
- GAP_CYCLES, 8: idle cycles after the last payload byte before the next request is accepted (≥0).
- MIN_LEN, 4: smallest legal payload length.
- MAX_LEN, 4096: largest legal payload length.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pkt_req  in  1  request to send a packet; sampled only in IDLE.
- pkt_type  in  8  packet type, captured on accept.
- pkt_length  in  16  payload byte count, captured on accept.
- pkt_ack  out  1  one-cycle pulse: request accepted.
- pkt_reject  out  1  one-cycle pulse: request refused because the length is illegal.
- pl_valid  in  1  payload byte available.
- pl_data  in  8  payload byte.
- pl_ready  out  1  framer takes `pl_data` this cycle if `pl_valid` is high.
- t2mi_valid  out  1  byte strobe, one cycle per emitted byte.
- t2mi_data  out  8  emitted byte; 0x00 whenever `t2mi_valid` is low.
- t2mi_sync  out  1  high only together with `t2mi_valid` on the 0x47 byte.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  one-cycle pulse per payload slot missed because `pl_valid` was low.
- pkt_count  out  16  count of completed packets; wraps 0xFFFF→0x0000.

## Operation
- FSM states: IDLE, SYNC, TYPE, LEN_HI, LEN_LO, PAYLOAD, GAP.
- IDLE:
  - If `pkt_req` is high and MIN_LEN ≤ `pkt_length` ≤ MAX_LEN: capture type and length, load `rem` = length, set `div_cnt` = 0, go to SYNC. `pkt_ack` is high in the next cycle.
  - If `pkt_req` is high and the length is illegal: `pkt_reject` is high in the next cycle, stay in IDLE, emit nothing.
- `pkt_req` in any state other than IDLE is ignored, with no ack and no reject.
- Slot rule: `div_cnt` counts 0..BYTE_DIV-1 and saturates at BYTE_DIV-1. A slot exists in any cycle where `div_cnt` = BYTE_DIV-1.
- Header states: on a slot edge, register `t2mi_valid`=1 and `t2mi_data` to the state's byte, then clear `div_cnt` and advance:
  - SYNC emits 0x47 with `t2mi_sync`=1.
  - TYPE emits the type byte.
  - LEN_HI emits length[15:8].
  - LEN_LO emits length[7:0].
- PAYLOAD:
  - `pl_ready` = (state==PAYLOAD && `div_cnt`==BYTE_DIV-1). This is combinational and never asserted in any other state.
  - Slot with `pl_valid`=1: emit `pl_data`, decrement `rem`, clear `div_cnt`.
  - Slot with `pl_valid`=0: no output, `underrun` pulses in the next cycle, `div_cnt` holds, and the framer retries every cycle until a byte arrives.
  - On the byte that makes `rem` reach 0: increment `pkt_count`, then go to GAP (or to IDLE if GAP_CYCLES=0).
- GAP: wait GAP_CYCLES cycles, then go to IDLE.
- Length is a 16-bit unsigned value, and `rem` is 16 bits wide.

## Timing
- Reset values:
  - `t2mi_valid`, `t2mi_sync`, `pkt_ack`, `pkt_reject`, `underrun`: 0.
  - `t2mi_data`: 0x00.
  - `busy`: 0.
  - `pkt_count`: 0x0000.
  - State: IDLE.
  - `pl_ready`: 0.
- Request latency: a request accepted in cycle N gives `pkt_ack` in N+1 and the sync byte on the outputs in cycle N+BYTE_DIV+1. Successive bytes follow every BYTE_DIV cycles when no underrun occurs.
- With BYTE_DIV=1 and a length-L packet with no stalls: `t2mi_valid` is high for L+4 consecutive cycles.
- `busy` is high from N+1 until the cycle in which the state returns to IDLE.
- Minimum spacing between packets: the last payload byte is emitted in cycle M; `busy` is low in cycle M+GAP_CYCLES+1; the next request can be accepted in that cycle.
- Reset mid-packet: the packet is abandoned at the next edge. All outputs take their reset values, no partial bytes follow, and `pkt_count` clears.
- Simultaneous `pkt_req` and last payload byte: the request is ignored unless it is still held in IDLE.

## Test plan
- BYTE_DIV=1. Request type 0x20, length 12, payload 0x00..0x0B always valid. Required: `t2mi_valid` high for 16 consecutive cycles carrying 47,20,00,0C,00..0B; `t2mi_sync` high only on the first byte; `pkt_count`=1.
- BYTE_DIV=4. Type 0xA5, length 256. Required: 260 strobes exactly 4 cycles apart; the length bytes are 01,00; payload bytes wrap 0xFF→0x00.
- Request with length 2, and separately with length MAX_LEN+1. Required: `pkt_reject` pulse each time, no `t2mi_valid`, `busy` stays 0, and no `pkt_ack`.
- Length 8 with `pl_valid` dropped for 3 cycles at byte 5. Required: 3 `underrun` pulses, payload order intact, total strobes = 12.
- `rst` asserted after the 6th strobe of a length-8 packet. Required: no further strobes, all outputs at reset values; a new length-4 request then emits 8 correct bytes.
- Request held high through a packet with GAP_CYCLES=8. Required: exactly one `pkt_ack` per packet, and the second sync byte appears no earlier than 9 cycles after the last payload byte.
